// File: rtl/spdif_sample_fifo.sv
// Stereo sample FIFO between the synthesis core and the S/PDIF encoder.
// Holds {left,right} pairs, pops on encoder right latches, mutes on underrun until refilled.
module spdif_sample_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int PREFILL    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           in_left,
    input  logic [15:0]           in_right,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  left_accepted,
    input  logic                  right_accepted,
    output logic [15:0]           out_left,
    output logic [15:0]           out_right,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underrun
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LP_FULL    = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LP_PREFILL = (DEPTH_LOG2 + 1)'(PREFILL);
    localparam logic [DEPTH_LOG2:0]   LP_LVL_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] LP_PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [0:0]            ST_FILL    = 1'b0;
    localparam logic [0:0]            ST_RUN     = 1'b1;

    logic [31:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wp;
    logic [DEPTH_LOG2-1:0] r_rp;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_left_seen;
    logic [0:0]            r_state;
    logic [15:0]           r_out_left;
    logic [15:0]           r_out_right;
    logic                  r_underrun;

    logic                  w_write;
    logic                  w_right_valid;
    logic                  w_pop;
    logic                  w_underrun;
    logic [31:0]           w_head;

    assign in_ready      = (r_level != LP_FULL);
    assign w_write       = in_valid && in_ready;
    assign w_right_valid = right_accepted && r_left_seen;
    assign w_head        = r_mem[r_rp];

    always_comb begin
        w_pop      = 1'b0;
        w_underrun = 1'b0;
        if (w_right_valid) begin
            if (r_state == ST_FILL) begin
                w_pop = (r_level >= LP_PREFILL);
            end else if (r_level != '0) begin
                w_pop = 1'b1;
            end else begin
                w_underrun = 1'b1;
            end
        end
    end

    // Storage is not reset: an empty level makes stale entries unreachable.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (w_write && (r_wp == DEPTH_LOG2'(gi))) begin
                    r_mem[gi] <= {in_left, in_right};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_level     <= '0;
            r_left_seen <= 1'b0;
            r_state     <= ST_FILL;
            r_out_left  <= '0;
            r_out_right <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_underrun <= w_underrun;
            if (w_write) begin
                r_wp <= r_wp + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rp <= r_rp + LP_PTR_ONE;
            end
            case ({w_write, w_pop})
                2'b10:   r_level <= r_level + LP_LVL_ONE;
                2'b01:   r_level <= r_level - LP_LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (left_accepted) begin
                r_left_seen <= 1'b1;
            end else if (w_right_valid) begin
                r_left_seen <= 1'b0;
            end
            if (w_pop) begin
                r_out_left  <= w_head[31:16];
                r_out_right <= w_head[15:0];
                r_state     <= ST_RUN;
            end else if (w_underrun) begin
                r_out_left  <= '0;
                r_out_right <= '0;
                r_state     <= ST_FILL;
            end
        end
    end

    assign out_left  = r_out_left;
    assign out_right = r_out_right;
    assign level     = r_level;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_spdif_sample_fifo.sv
// Directed bench for spdif_sample_fifo: prefill, alignment, simultaneous ops, full, underrun, reset.
module tb_spdif_sample_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        left_accepted = 1'b0;
    logic        right_accepted = 1'b0;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic [3:0]  level;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    spdif_sample_fifo #(.DEPTH_LOG2(3), .PREFILL(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_left        (in_left),
        .in_right       (in_right),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .left_accepted  (left_accepted),
        .right_accepted (right_accepted),
        .out_left       (out_left),
        .out_right      (out_right),
        .level          (level),
        .underrun       (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] l, input logic [15:0] r);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic lpulse();
        left_accepted = 1'b1;
        step();
        left_accepted = 1'b0;
    endtask

    task automatic rpulse();
        right_accepted = 1'b1;
        step();
        right_accepted = 1'b0;
    endtask

    task automatic lr(input int gap);
        lpulse();
        repeat (gap) step();
        rpulse();
    endtask

    task automatic chk_out(input string tag, input logic [15:0] l, input logic [15:0] r,
                           input logic [3:0] lv);
        chk({tag, "_out"}, {out_left, out_right}, {l, r});
        chk({tag, "_level"}, {28'd0, level}, {28'd0, lv});
    endtask

    initial begin
        // Reset state, including a lost write during reset
        #1 reset = 1'b1;
        #1;
        chk("rst_out", {out_left, out_right}, 32'h0);
        chk("rst_level", {28'd0, level}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        in_left = 16'hDEAD; in_right = 16'hBEEF; in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        reset = 1'b0;
        chk("rst_write_lost", {28'd0, level}, 32'd0);

        // Prefill: below threshold no pop happens
        wr(16'h1111, 16'h2222);
        wr(16'h2222, 16'h3333);
        lr(62);
        chk_out("prefill_lvl2", 16'h0, 16'h0, 4'd2);
        wr(16'h3333, 16'h4444);
        wr(16'h4444, 16'h5555);
        chk("prefill_lvl4", {28'd0, level}, 32'd4);
        lr(62);
        chk_out("prefill_pop", 16'h1111, 16'h2222, 4'd3);
        repeat (20) step();
        chk_out("hold_stable", 16'h1111, 16'h2222, 4'd3);

        // Alignment: an orphan right latch is ignored
        rpulse();
        chk_out("orphan_right", 16'h1111, 16'h2222, 4'd3);
        lr(4);
        chk_out("aligned_pop", 16'h2222, 16'h3333, 4'd2);

        // Simultaneous write and pop at level 2
        lpulse();
        in_left = 16'h5555; in_right = 16'h6666; in_valid = 1'b1;
        right_accepted = 1'b1;
        step();
        in_valid = 1'b0; right_accepted = 1'b0;
        chk_out("simul_lvl2", 16'h3333, 16'h4444, 4'd2);

        // Full: fill to 8, 9th pair stalls until after the first pop
        for (int k = 6; k <= 11; k++) begin
            wr(16'(k * 16'h1111), 16'(k * 16'h1111 + 16'h1111));
        end
        chk("full_level", {28'd0, level}, 32'd8);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        in_left = 16'hCCCC; in_right = 16'hDDDD; in_valid = 1'b1;
        step();
        chk("full_stall", {28'd0, level}, 32'd8);
        lr(2);
        chk_out("full_pop", 16'h4444, 16'h5555, 4'd7);
        chk("full_ready_after_pop", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("full_ninth_in", {28'd0, level}, 32'd8);
        for (int k = 5; k <= 12; k++) begin
            lr(2);
            chk_out($sformatf("drain%0d", k), 16'(k * 16'h1111),
                    16'(k * 16'h1111 + 16'h1111), 4'(12 - k));
        end

        // Underrun: empty pop in RUN mutes and pulses underrun for one cycle
        lr(2);
        chk_out("underrun_mute", 16'h0, 16'h0, 4'd0);
        chk("underrun_pulse", {31'd0, underrun}, 32'd1);
        step();
        chk("underrun_clear", {31'd0, underrun}, 32'd0);

        // Back in FILL: outputs stay muted until prefill level
        wr(16'hA001, 16'hB001);
        wr(16'hA002, 16'hB002);
        lr(2);
        chk_out("refill_lvl2", 16'h0, 16'h0, 4'd2);
        chk("refill_no_underrun", {31'd0, underrun}, 32'd0);
        wr(16'hA003, 16'hB003);
        wr(16'hA004, 16'hB004);
        lr(2);
        chk_out("refill_pop", 16'hA001, 16'hB001, 4'd3);
        for (int k = 2; k <= 4; k++) begin
            lr(2);
            chk_out($sformatf("refill_drain%0d", k), 16'(16'hA000 + k),
                    16'(16'hB000 + k), 4'(4 - k));
        end

        // Simultaneous write and pop at level 0 in RUN: underrun, pair stored
        lpulse();
        in_left = 16'hA005; in_right = 16'hB005; in_valid = 1'b1;
        right_accepted = 1'b1;
        step();
        in_valid = 1'b0; right_accepted = 1'b0;
        chk_out("simul_lvl0", 16'h0, 16'h0, 4'd1);
        chk("simul_lvl0_underrun", {31'd0, underrun}, 32'd1);

        // Reset mid-operation with level 5 and nonzero outputs
        wr(16'hA006, 16'hB006);
        wr(16'hA007, 16'hB007);
        wr(16'hA008, 16'hB008);
        lr(2);
        chk_out("pre_reset_pop", 16'hA005, 16'hB005, 4'd3);
        wr(16'hA009, 16'hB009);
        wr(16'hA00A, 16'hB00A);
        chk("pre_reset_level", {28'd0, level}, 32'd5);
        #2 reset = 1'b1;
        #1;
        chk_out("async_reset", 16'h0, 16'h0, 4'd0);
        chk("async_reset_ready", {31'd0, in_ready}, 32'd1);
        step();
        reset = 1'b0;

        // Prefill sequence repeats after reset
        wr(16'h1111, 16'h2222);
        wr(16'h2222, 16'h3333);
        wr(16'h3333, 16'h4444);
        lr(2);
        chk_out("post_reset_lvl3", 16'h0, 16'h0, 4'd3);
        wr(16'h4444, 16'h5555);
        lr(2);
        chk_out("post_reset_pop", 16'h1111, 16'h2222, 4'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spdif_sample_fifo.md
# spdif_sample_fifo

Stereo sample buffer feeding the S/PDIF encoder. It accepts 16-bit left/right pairs from the synthesis core through a valid/ready handshake and stores them in a small register FIFO. It presents the head pair on steady outputs wired to the encoder's `left_in`/`right_in`, and pops on the encoder's `right_accepted` pulse. Underruns mute the output to zero until the FIFO refills to a prefill threshold.

## Interface
- `DEPTH_LOG2`, default 3: FIFO depth is 2^DEPTH_LOG2 stereo pairs. Legal range 1..6.
- `PREFILL`, default 4: level (pairs) required before leaving FILL. Legal range 1..2^DEPTH_LOG2.
- `clk`  in  1  system clock; same clock as the encoder.
- `reset`  in  1  asynchronous, active-high.
- `in_left`  in  16  left sample from the synthesis core.
- `in_right`  in  16  right sample, same pair as `in_left`.
- `in_valid`  in  1  pair on `in_left`/`in_right` is valid.
- `in_ready`  out  1  FIFO can accept a pair this cycle.
- `left_accepted`  in  1  1-cycle pulse from the encoder: left sample latched.
- `right_accepted`  in  1  1-cycle pulse from the encoder: right sample latched.
- `out_left`  out  16  left sample to the encoder; registered.
- `out_right`  out  16  right sample to the encoder; registered.
- `level`  out  DEPTH_LOG2+1  pairs currently stored; registered.
- `underrun`  out  1  1-cycle pulse when a pop finds the FIFO empty in RUN.

## Operation
- **Storage:** 2^DEPTH_LOG2 × 32-bit register array, holding {left, right}.
  - Write pointer `wp` and read pointer `rp`, each DEPTH_LOG2 bits, wrap naturally modulo depth.
  - `level` is tracked separately: +1 on write only, −1 on pop only, unchanged on write and pop in the same cycle.
- **Write:** occurs when `in_valid && in_ready`. `in_ready = (level != 2^DEPTH_LOG2)`, combinational from the `level` register.
  - A write while full is impossible by handshake. `in_valid` with `in_ready` low simply stalls the source; nothing is lost.
- **Pair alignment flag `left_seen`:**
  - Set on `left_accepted`.
  - Cleared when a `right_accepted` is processed.
  - A `right_accepted` with `left_seen`=0 is ignored: no pop, no state change.
- **State machine:** two states, FILL and RUN. Reset enters FILL.
  - FILL: `out_left`/`out_right` are held at 0. On a valid `right_accepted`:
    - if `level >= PREFILL`: pop the head pair into the output registers and go to RUN;
    - otherwise stay in FILL and keep outputs at 0.
  - RUN: on a valid `right_accepted`:
    - if `level != 0`: pop the head pair into the output registers;
    - if `level == 0`: load 0/0, pulse `underrun`, go to FILL.
- **Simultaneous write and pop:**
  - The pop reads the pre-write head.
  - With `level==0`, a same-cycle write does not bypass to the outputs. This is an underrun, and the written pair is stored.
- `left_accepted` never pops and never changes the outputs.
- Samples pass through unmodified; there is no arithmetic on sample data.

## Timing
- **Reset values:** `out_left`=0, `out_right`=0, `level`=0, `underrun`=0, `in_ready`=1, `wp`=`rp`=0, `left_seen`=0, state=FILL.
- **Write latency:** a pair written at edge t is reflected in `level` after edge t. It is poppable by a `right_accepted` sampled at edge t+1 or later.
- **Pop timing:**
  - A `right_accepted` sampled high at edge t updates `out_left`/`out_right`/`level` at edge t.
  - `underrun` is high during cycle t+1 only.
  - Outputs then stay constant until the next processed `right_accepted`. With the encoder's 64-cycle subframe, that leaves 63 stable cycles before the next left latch.
- **Reset mid-operation:**
  - All stored pairs are discarded and outputs return to 0 asynchronously.
  - A write handshake in the reset cycle is lost.
- Throughput: one write per cycle while not full; at most one pop per 128 cycles in practice, one per cycle tolerated.

## Test plan
- **Prefill:** reset, write pairs (0x1111,0x2222)…(0x4444,0x5555) (4 pairs), drive L/R pulses every 64 cycles -> outputs 0 until the first `right_accepted` with level 4, then 0x1111/0x2222; level goes 4→3.
- **Full:** with DEPTH_LOG2=3, write 8 pairs with no pops -> `in_ready`=0, level=8; the 9th pair is held by the source and enters on the cycle after the first pop; the pairs appear at the outputs in order.
- **Underrun:** drain the FIFO to empty in RUN, next `right_accepted` -> outputs 0/0, one-cycle `underrun`, state FILL; outputs stay 0 until level reaches PREFILL again.
- **Simultaneous:** with level 2, write and valid `right_accepted` in the same cycle -> level stays 2, outputs show the old head; with level 0 in RUN, the same event -> underrun, level 1.
- **Alignment:** `right_accepted` without a preceding `left_accepted` -> no pop, level unchanged; a subsequent L then R -> normal pop.
- **Reset:** assert reset while level=5 and outputs nonzero -> immediate 0 outputs, level 0, `in_ready`=1; after release the prefill sequence repeats correctly.
